// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//   Fully registered binary adder tree that reduces N_IN operands of WIDTH bits to one
//   full-precision sum of WIDTH+$clog2(N_IN) bits. There is one register level per tree level.
//   Every level advances together under one global enable, so bubbles are not compressed.
//
// Parameters
//   N_IN    number of operands (>= 2). It need not be a power of two.
//   WIDTH   bits per operand
//   SIGNED  1: two's-complement operands (sign-extended), 0: unsigned (zero-extended)
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset; clears every valid bit and data register
//   in_valid   in_data carries an operand set
//   in_ready   set accepted this cycle (depends only on out_ready/out_valid)
//   in_data    operand k at bits [k*WIDTH +: WIDTH]
//   out_valid  out_sum holds a finished sum
//   out_ready  downstream takes out_sum this cycle
//   out_sum    exact sum of all operands
//   sum_count  (only with ADDER_TREE_CNT_EN defined) number of output transfers, wraps at 2^32
//
// Optional feature macro: ADDER_TREE_CNT_EN
module pipelined_adder_tree #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_IN*WIDTH-1:0]            in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH+$clog2(N_IN)-1:0]    out_sum
`ifdef ADDER_TREE_CNT_EN
  ,
  output logic [31:0]                      sum_count
`endif
);

  localparam int unsigned LEVELS = $clog2(N_IN);
  localparam int unsigned OUT_W  = WIDTH + LEVELS;

  // Number of partial sums held at tree level s (level 0 = the raw operands).
  function automatic int unsigned level_cnt(input int unsigned s);
    return (N_IN + (32'd1 << s) - 32'd1) >> s;
  endfunction

  logic              w_adv;
  logic [LEVELS-1:0] r_valid;

  // Every tree value, extended to OUT_W per SIGNED. A level reads the low WIDTH+s bits of
  // its predecessor, which is exactly the 1-bit extension of that predecessor.
  logic [OUT_W-1:0]  w_lvl [LEVELS+1][N_IN];

  assign w_adv     = out_ready || !out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[LEVELS-1];
  assign out_sum   = w_lvl[LEVELS][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_adv) begin
      r_valid <= (r_valid << 1) | LEVELS'(in_valid);
    end
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_leaf
    if (SIGNED) begin : g_sx
      assign w_lvl[0][k] = OUT_W'($signed(in_data[k*WIDTH +: WIDTH]));
    end else begin : g_zx
      assign w_lvl[0][k] = OUT_W'(in_data[k*WIDTH +: WIDTH]);
    end
  end

  for (genvar s = 1; s <= LEVELS; s++) begin : g_lvl
    localparam int unsigned W    = WIDTH + s;
    localparam int unsigned CNT  = level_cnt(s);
    localparam int unsigned PCNT = level_cnt(s - 1);

    for (genvar k = 0; k < N_IN; k++) begin : g_node
      if (k < CNT) begin : g_used
        logic [W-1:0] r_data;
        logic [W-1:0] w_next;

        if (2 * k + 1 < PCNT) begin : g_add
          assign w_next = w_lvl[s-1][2*k][W-1:0] + w_lvl[s-1][2*k+1][W-1:0];
        end else begin : g_pass
          // Odd element out: carried forward unchanged, one bit wider.
          assign w_next = w_lvl[s-1][2*k][W-1:0];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_data <= '0;
          end else if (w_adv) begin
            r_data <= w_next;
          end
        end

        if (SIGNED) begin : g_sx
          assign w_lvl[s][k] = OUT_W'($signed(r_data));
        end else begin : g_zx
          assign w_lvl[s][k] = OUT_W'(r_data);
        end
      end else begin : g_unused
        assign w_lvl[s][k] = '0;
      end
    end
  end

`ifdef ADDER_TREE_CNT_EN
  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (out_valid && out_ready) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign sum_count = r_count;
`endif

endmodule
